// File: rtl/io_fifo_pkg.sv
// Shared constants for the I/O-mapped byte FIFO peripheral: register offsets,
// status/control bit positions and the FIFO count width.
package io_fifo_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_COUNT  = 2'd3
  } reg_off_e;

  localparam int ST_RX_EMPTY  = 0;
  localparam int ST_RX_FULL   = 1;
  localparam int ST_TX_EMPTY  = 2;
  localparam int ST_TX_FULL   = 3;
  localparam int ST_TX_OVF    = 4;
  localparam int ST_RX_UDF    = 5;
  localparam int ST_IRQ       = 7;

  localparam int CTL_IRQ_EN_RX  = 0;
  localparam int CTL_IRQ_EN_TX  = 1;
  localparam int CTL_CLR_STICKY = 7;

  // Occupancy after one cycle given the accepted push/pop of that cycle.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic push, input logic pop);
    logic [CNT_W-1:0] r;
    r = cnt;
    if (push && !pop) r = cnt + CNT_W'(1);
    else if (pop && !push) r = cnt - CNT_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/io_fifo_port_if.sv
// Bus-side and device-side signals of the FIFO peripheral; Data stays a plain
// inout on the top because it is a shared tristate line.
interface io_fifo_port_if;
  logic [19:0] Address;
  logic        RD;
  logic        WR;
  logic        IOM;
  logic        CS;
  logic        IRQ;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport master (
    output Address, RD, WR, IOM, CS, tx_ready, rx_data, rx_valid,
    input  IRQ, tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  Address, RD, WR, IOM, CS, tx_ready, rx_data, rx_valid,
    output IRQ, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with DEPTH entries (2..15); a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo
  import io_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  // Storage is sized to the pointer range so indexing stays width-exact.
  logic [WIDTH-1:0] r_mem [2**CNT_W];
  logic [CNT_W-1:0] r_wptr;
  logic [CNT_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop_acc;
  logic             w_push_acc;

  function automatic logic [CNT_W-1:0] ptr_inc(input logic [CNT_W-1:0] p);
    return (p == CNT_W'(DEPTH - 1)) ? '0 : p + CNT_W'(1);
  endfunction

  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_dout     = r_mem[r_rptr];
  assign w_pop_acc  = i_pop & ~o_empty;
  assign w_push_acc = i_push & (~o_full | w_pop_acc);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_acc) r_wptr <= ptr_inc(r_wptr);
      if (w_pop_acc)  r_rptr <= ptr_inc(r_rptr);
      r_count <= cnt_next(r_count, w_push_acc, w_pop_acc);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_acc) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/io_fifo_port.sv
// 8088 I/O-mapped byte FIFO peripheral: strobe edge detection, register decode,
// sticky error flags, registered IRQ and the Data tristate around two FIFOs.
module io_fifo_port
  import io_fifo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic         CLK,
  input  logic         RESET_N,
  inout  wire  [7:0]   Data,
  io_fifo_port_if.slave bus
);

  logic             r_wr_q, r_rd_q;
  logic             r_wr_arm, r_rd_arm;
  logic             r_void;
  logic             r_wpend, r_rpend;
  reg_off_e         r_waddr, r_raddr;
  logic [7:0]       r_wdata;
  logic [1:0]       r_en;
  logic             r_tx_ovf, r_rx_udf, r_irq;

  logic             w_sel, w_both, w_wr_cap, w_rd_cap;
  logic             w_wr_rise, w_rd_rise, w_commit, w_rd_done;
  logic             w_tx_push, w_tx_pop, w_ctl_wr, w_clr;
  logic             w_rx_push, w_rx_pop;
  logic             w_tx_push_acc, w_rx_pop_acc;
  logic             w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [7:0]       w_tx_dout, w_rx_dout;
  logic [CNT_W-1:0] w_tx_cnt, w_rx_cnt, w_tx_cnt_nxt, w_rx_cnt_nxt;
  logic [1:0]       w_en_nxt;
  logic             w_irq_nxt, w_drive;
  logic [7:0]       w_rdata;
  logic             w_unused;

  assign w_unused  = ^bus.Address[19:2];

  assign w_sel     = ~bus.CS & bus.IOM;
  assign w_both    = ~bus.RD & ~bus.WR;
  // Arm bits keep a strobe that was already low at reset release from committing.
  assign w_wr_cap  = w_sel & ~bus.WR & bus.RD & r_wr_arm & ~r_void;
  assign w_rd_cap  = w_sel & ~bus.RD & bus.WR & r_rd_arm & ~r_void;
  assign w_wr_rise = ~r_wr_q & bus.WR;
  assign w_rd_rise = ~r_rd_q & bus.RD;
  assign w_commit  = w_wr_rise & r_wpend;
  assign w_rd_done = w_rd_rise & r_rpend;

  assign w_tx_push = w_commit & (r_waddr == REG_DATA);
  assign w_ctl_wr  = w_commit & (r_waddr == REG_CTRL);
  assign w_clr     = w_ctl_wr & r_wdata[CTL_CLR_STICKY];
  assign w_tx_pop  = ~w_tx_empty & bus.tx_ready;
  assign w_rx_pop  = w_rd_done & (r_raddr == REG_DATA);
  assign w_rx_push = bus.rx_valid & ~w_rx_full;

  assign w_tx_push_acc = w_tx_push & (~w_tx_full | w_tx_pop);
  assign w_rx_pop_acc  = w_rx_pop & ~w_rx_empty;
  assign w_tx_cnt_nxt  = cnt_next(w_tx_cnt, w_tx_push_acc, w_tx_pop);
  assign w_rx_cnt_nxt  = cnt_next(w_rx_cnt, w_rx_push, w_rx_pop_acc);
  assign w_en_nxt      = w_ctl_wr ? r_wdata[1:0] : r_en;
  assign w_irq_nxt     = (w_en_nxt[CTL_IRQ_EN_RX] & (w_rx_cnt_nxt != '0)) |
                         (w_en_nxt[CTL_IRQ_EN_TX] & (w_tx_cnt_nxt == '0));

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_push  (w_tx_push),
    .i_pop   (w_tx_pop),
    .i_din   (r_wdata),
    .o_dout  (w_tx_dout),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_cnt)
  );

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_push  (w_rx_push),
    .i_pop   (w_rx_pop),
    .i_din   (bus.rx_data),
    .o_dout  (w_rx_dout),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_cnt)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr_q   <= 1'b1;
      r_rd_q   <= 1'b1;
      r_wr_arm <= 1'b0;
      r_rd_arm <= 1'b0;
      r_void   <= 1'b0;
      r_wpend  <= 1'b0;
      r_rpend  <= 1'b0;
      r_waddr  <= REG_DATA;
      r_raddr  <= REG_DATA;
      r_en     <= '0;
      r_tx_ovf <= 1'b0;
      r_rx_udf <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_wr_q <= bus.WR;
      r_rd_q <= bus.RD;
      if (bus.WR) r_wr_arm <= 1'b1;
      if (bus.RD) r_rd_arm <= 1'b1;
      // A cycle with both strobes low is void until both return high.
      if (w_both) r_void <= 1'b1;
      else if (bus.RD & bus.WR) r_void <= 1'b0;

      if (w_both) r_wpend <= 1'b0;
      else if (w_wr_cap) begin
        r_wpend <= 1'b1;
        r_waddr <= reg_off_e'(bus.Address[1:0]);
      end else if (w_wr_rise) r_wpend <= 1'b0;

      if (w_both) r_rpend <= 1'b0;
      else if (w_rd_cap) begin
        r_rpend <= 1'b1;
        r_raddr <= reg_off_e'(bus.Address[1:0]);
      end else if (w_rd_rise) r_rpend <= 1'b0;

      r_en     <= w_en_nxt;
      r_tx_ovf <= (r_tx_ovf & ~w_clr) | (w_tx_push & w_tx_full & ~w_tx_pop);
      r_rx_udf <= (r_rx_udf & ~w_clr) | (w_rx_pop & w_rx_empty);
      r_irq    <= w_irq_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr_cap) r_wdata <= Data;
  end

  always_comb begin
    w_rdata = '0;
    unique case (reg_off_e'(bus.Address[1:0]))
      REG_DATA:   w_rdata = w_rx_empty ? 8'h00 : w_rx_dout;
      REG_STATUS: begin
        w_rdata[ST_RX_EMPTY] = w_rx_empty;
        w_rdata[ST_RX_FULL]  = w_rx_full;
        w_rdata[ST_TX_EMPTY] = w_tx_empty;
        w_rdata[ST_TX_FULL]  = w_tx_full;
        w_rdata[ST_TX_OVF]   = r_tx_ovf;
        w_rdata[ST_RX_UDF]   = r_rx_udf;
        w_rdata[ST_IRQ]      = r_irq;
      end
      REG_CTRL:   w_rdata[1:0] = r_en;
      REG_COUNT:  w_rdata = {w_tx_cnt, w_rx_cnt};
      default:    w_rdata = '0;
    endcase
  end

  assign w_drive      = RESET_N & w_sel & ~bus.RD & bus.WR;
  assign Data         = w_drive ? w_rdata : 8'hzz;

  assign bus.IRQ      = r_irq;
  assign bus.tx_data  = w_tx_dout;
  assign bus.tx_valid = ~w_tx_empty;
  assign bus.rx_ready = ~w_rx_full;

endmodule

// File: tb/tb_io_fifo_port.sv
// Directed bench for io_fifo_port: bus register access, both FIFO paths,
// overflow/underflow, full boundary and reset in the middle of a write.
module tb_io_fifo_port;
  import io_fifo_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  wire  [7:0] Data;
  logic       r_drv = 1'b0;
  logic [7:0] r_dout = 8'h00;
  logic [7:0] rd;
  int         n_tests = 0;
  int         n_fail = 0;

  assign Data = r_drv ? r_dout : 8'hzz;

  io_fifo_port_if bus ();

  io_fifo_port #(.DEPTH(8)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .Data    (Data),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input bit pop_at_commit);
    @(negedge CLK);
    bus.Address = {18'h0, a};
    r_dout = d; r_drv = 1'b1;
    bus.CS = 1'b0; bus.IOM = 1'b1; bus.WR = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    bus.WR = 1'b1;
    if (pop_at_commit) bus.tx_ready = 1'b1;
    @(negedge CLK);
    bus.CS = 1'b1; r_drv = 1'b0;
    if (pop_at_commit) bus.tx_ready = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge CLK);
    bus.Address = {18'h0, a};
    bus.CS = 1'b0; bus.IOM = 1'b1; bus.RD = 1'b0;
    @(negedge CLK);
    d = Data;
    bus.RD = 1'b1;
    @(negedge CLK);
    bus.CS = 1'b1;
  endtask

  logic [7:0] drain_exp [8] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h99};

  initial begin
    bus.Address = '0; bus.RD = 1'b1; bus.WR = 1'b1; bus.IOM = 1'b1; bus.CS = 1'b1;
    bus.tx_ready = 1'b0; bus.rx_data = 8'h00; bus.rx_valid = 1'b0;

    // Reset
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    check("rst_irq", {7'b0, bus.IRQ}, 8'h00);
    check("rst_tx_valid", {7'b0, bus.tx_valid}, 8'h00);
    check("rst_rx_ready", {7'b0, bus.rx_ready}, 8'h01);
    bus_read(2'd1, rd); check("rst_status", rd, 8'h05);
    bus_read(2'd3, rd); check("rst_count", rd, 8'h00);

    // TX path
    bus_write(2'd0, 8'hA5, 0);
    bus_write(2'd0, 8'h3C, 0);
    bus_read(2'd3, rd); check("tx_count2", rd, 8'h20);
    check("tx_head", bus.tx_data, 8'hA5);
    check("tx_valid", {7'b0, bus.tx_valid}, 8'h01);
    bus.tx_ready = 1'b1;
    @(negedge CLK);
    check("tx_second", bus.tx_data, 8'h3C);
    check("tx_valid2", {7'b0, bus.tx_valid}, 8'h01);
    @(negedge CLK);
    check("tx_drained", {7'b0, bus.tx_valid}, 8'h00);
    bus.tx_ready = 1'b0;
    bus_read(2'd1, rd); check("tx_status_empty", rd, 8'h05);

    // TX overflow
    for (int i = 0; i < 9; i++) bus_write(2'd0, 8'h40 + 8'(i), 0);
    bus_read(2'd1, rd); check("ovf_status", rd, 8'h19);
    bus_read(2'd3, rd); check("ovf_count", rd, 8'h80);
    bus_write(2'd2, 8'h80, 0);
    bus_read(2'd1, rd); check("ovf_cleared", rd, 8'h09);
    bus_read(2'd2, rd); check("ctrl_after_clr", rd, 8'h00);

    // Push into full TX with a same-cycle pop
    bus_write(2'd0, 8'h99, 1);
    bus_read(2'd3, rd); check("full_pp_count", rd, 8'h80);
    bus_read(2'd1, rd); check("full_pp_status", rd, 8'h09);
    bus.tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("drain", bus.tx_data, drain_exp[k]);
      @(negedge CLK);
    end
    bus.tx_ready = 1'b0;
    check("drain_empty", {7'b0, bus.tx_valid}, 8'h00);

    // RX path and IRQ
    bus_write(2'd2, 8'h01, 0);
    bus_read(2'd2, rd); check("ctrl_rb", rd, 8'h01);
    check("irq_idle", {7'b0, bus.IRQ}, 8'h00);
    @(negedge CLK);
    bus.rx_data = 8'h11; bus.rx_valid = 1'b1;
    @(negedge CLK);
    bus.rx_valid = 1'b0;
    check("irq_rx", {7'b0, bus.IRQ}, 8'h01);
    bus_read(2'd1, rd); check("rx_status", rd, 8'h84);
    bus_read(2'd3, rd); check("rx_count1", rd, 8'h01);
    bus_read(2'd0, rd); check("rx_pop", rd, 8'h11);
    check("irq_fall", {7'b0, bus.IRQ}, 8'h00);
    bus_read(2'd0, rd); check("rx_underflow_data", rd, 8'h00);
    bus_read(2'd1, rd); check("rx_underflow_status", rd, 8'h25);

    // RX full boundary
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      bus.rx_data = 8'h20 + 8'(i); bus.rx_valid = 1'b1;
    end
    @(negedge CLK);
    bus.rx_valid = 1'b0;
    check("rx_full_ready", {7'b0, bus.rx_ready}, 8'h00);
    bus_read(2'd3, rd); check("rx_count8", rd, 8'h08);
    @(negedge CLK);
    bus.Address = 20'h0; bus.CS = 1'b0; bus.IOM = 1'b1; bus.RD = 1'b0;
    bus.rx_data = 8'h77; bus.rx_valid = 1'b1;
    @(negedge CLK);
    check("full_pop_data", Data, 8'h20);
    bus.RD = 1'b1;
    @(negedge CLK);
    check("rx_ready_after_pop", {7'b0, bus.rx_ready}, 8'h01);
    @(negedge CLK);
    check("rx_ready_refull", {7'b0, bus.rx_ready}, 8'h00);
    bus.rx_valid = 1'b0; bus.CS = 1'b1;
    bus_read(2'd3, rd); check("rx_count_back8", rd, 8'h08);
    bus_read(2'd0, rd); check("rx_next_head", rd, 8'h21);

    // Reset in the middle of a write cycle
    @(negedge CLK);
    bus.Address = 20'h0; r_dout = 8'hFF; r_drv = 1'b1;
    bus.CS = 1'b0; bus.IOM = 1'b1; bus.WR = 1'b0;
    @(negedge CLK);
    #2 RESET_N = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    bus.WR = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    bus.CS = 1'b1; r_drv = 1'b0;
    check("midrst_tx_valid", {7'b0, bus.tx_valid}, 8'h00);
    bus_read(2'd3, rd); check("midrst_count", rd, 8'h00);
    bus_read(2'd1, rd); check("midrst_status", rd, 8'h05);
    bus_read(2'd2, rd); check("midrst_ctrl", rd, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
